// File: rtl/montgomery_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// One iteration per cycle over the bits of a, then a single conditional subtraction.
module montgomery_mul_serial #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             error_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [SW-1:0]    s_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q;

    logic             last_iter;
    logic [SW-1:0]    s_add;
    logic [SW-1:0]    s_red;
    logic [SW-1:0]    s_next_iter;
    logic             s_ge_m;
    logic [WIDTH-1:0] s_sub;
    logic [WIDTH-1:0] final_result;

    // a is shifted right each iteration, so its bit 0 is always the current a[i].
    always_comb begin
        last_iter    = (cnt_q == CW'(WIDTH - 1));
        s_add        = s_q + (a_q[0] ? {2'b00, b_q} : {SW{1'b0}});
        s_red        = s_add[0] ? (s_add + {2'b00, m_q}) : s_add;
        s_next_iter  = s_red >> 1;
        s_ge_m       = (s_q >= {2'b00, m_q});
        s_sub        = s_q[WIDTH-1:0] - m_q;
        final_result = err_q ? {WIDTH{1'b0}}
                             : (s_ge_m ? s_sub : s_q[WIDTH-1:0]);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = m_i[0] ? RUN : FINAL;
            RUN:     if (last_iter) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != IDLE);
        end
    end

    // Operands are captured only on acceptance, so input changes mid-operation are harmless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            result_o <= '0;
            valid_o  <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q   <= a_i;
                        b_q   <= mode_i ? WIDTH'(1) : b_i;
                        m_q   <= m_i;
                        s_q   <= '0;
                        cnt_q <= '0;
                        err_q <= ~m_i[0];
                    end
                end
                RUN: begin
                    s_q   <= s_next_iter;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                FINAL: begin
                    result_o <= final_result;
                    valid_o  <= 1'b1;
                    error_o  <= err_q;
                end
                default: begin
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
